// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   - func_3 access codes (size in bits [1:0], unsigned flag in bit [2])
//   - FSM state enum and access-size enum
//   - lane-width constants and size/fault helpers
package lsu_pkg;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  localparam int BYTE_W    = 8;
  localparam int HALF_W    = 16;
  localparam int WORD_W    = 32;
  localparam int NUM_LANES = WORD_W / BYTE_W;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } lsu_state_t;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } lsu_size_t;

  // Undefined codes (011, 110, 111) fall into the word bucket.
  function automatic lsu_size_t lsu_size(input logic [2:0] f3);
    lsu_size_t sz;
    case (f3)
      LSU_B, LSU_BU: sz = SZ_BYTE;
      LSU_H, LSU_HU: sz = SZ_HALF;
      default:       sz = SZ_WORD;
    endcase
    return sz;
  endfunction

  // Alignment fault for a given size and byte offset; bytes never fault.
  function automatic logic lsu_fault(input lsu_size_t sz, input logic [1:0] off);
    logic f;
    case (sz)
      SZ_HALF: f = off[0];
      SZ_WORD: f = (off != 2'b00);
      default: f = 1'b0;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory port bundle between the load/store unit and memory.
//   master (LSU): drives mem_req, mem_we, mem_addr, mem_wdata, mem_byte_enable;
//                 receives mem_ready, mem_rdata.
//   slave (memory): the mirror image.
interface load_store_unit_if
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);

  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [NUM_LANES-1:0]  mem_byte_enable;
  logic                  mem_ready;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_byte_enable,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_byte_enable,
    output mem_ready, mem_rdata
  );

endinterface

// File: rtl/lsu_load_align.sv
// Combinational load extraction: picks the byte/half/word addressed by the
// registered offset out of the memory word and sign- or zero-extends it.
//   word   : raw memory read word
//   off    : byte offset of the access within the word
//   func_3 : access size and signedness
//   result : extended value for register write-back
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [WORD_W-1:0] word,
  input  logic [1:0]        off,
  input  logic [2:0]        func_3,
  output logic [WORD_W-1:0] result
);

  logic [BYTE_W-1:0] lanes [NUM_LANES];
  logic [BYTE_W-1:0] byte_val;
  logic [HALF_W-1:0] half_val;
  logic              sign_ext;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      assign lanes[gi] = word[gi*BYTE_W +: BYTE_W];
    end
  endgenerate

  assign byte_val = lanes[off];
  assign half_val = off[1] ? word[WORD_W-1:HALF_W] : word[HALF_W-1:0];
  // Bit 2 of func_3 marks the unsigned variants.
  assign sign_ext = ~func_3[2];

  always_comb begin
    result = word;
    case (lsu_size(func_3))
      SZ_BYTE: result = {{(WORD_W-BYTE_W){sign_ext & byte_val[BYTE_W-1]}}, byte_val};
      SZ_HALF: result = {{(WORD_W-HALF_W){sign_ext & half_val[HALF_W-1]}}, half_val};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit. Accepts a decoder load/store strobe, checks
// alignment, registers a lane-aligned memory transaction, stalls the core
// until memory answers and returns the extended load result.
//   clk, rst     : clock and synchronous active-high reset
//   load, store  : decoder strobes (store wins if both are high)
//   func_3       : access size / signedness
//   address      : byte address
//   store_data   : rs2 value
//   load_data    : registered extended load result
//   stall        : hold the pipeline
//   misaligned   : combinational alignment fault for the current request
//   mem          : data-memory port (master side)
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  store,
  input  logic [2:0]            func_3,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] store_data,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic                  stall,
  output logic                  misaligned,
  load_store_unit_if.master     mem
);

  lsu_state_t state_reg, state_next;

  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;
  logic [NUM_LANES-1:0]  be_reg;
  logic                  we_reg;
  logic [2:0]            func3_reg;
  logic [1:0]            off_reg;
  logic [DATA_WIDTH-1:0] load_data_reg;

  logic [1:0]            off;
  lsu_size_t             size;
  logic                  req;
  logic                  fault;
  logic                  accept;
  logic                  complete;
  logic [NUM_LANES-1:0]  be_store;
  logic [NUM_LANES-1:0]  be_next;
  logic [DATA_WIDTH-1:0] wdata_next;
  logic [DATA_WIDTH-1:0] align_result;

  assign off   = address[1:0];
  assign size  = lsu_size(func_3);
  assign req   = load | store;
  assign fault = lsu_fault(size, off);

  assign misaligned = req & (state_reg == IDLE) & fault;
  assign accept     = req & (state_reg == IDLE) & ~fault;
  assign stall      = accept | (state_reg == ACCESS);
  // mem_ready only matters while a request is on the bus.
  assign complete   = (state_reg == ACCESS) & mem.mem_ready;

  // Store byte enables; a half store can only sit in lanes 0-1 or 2-3.
  always_comb begin
    be_store = 4'b1111;
    case (size)
      SZ_BYTE: be_store = 4'b0001 << off;
      SZ_HALF: be_store = 4'b0011 << {off[1], 1'b0};
      default: be_store = 4'b1111;
    endcase
  end

  assign be_next = store ? be_store : 4'b1111;

  // Replicate the stored byte/half across every lane so the enables alone
  // choose what memory writes.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_wlane
      assign wdata_next[gi*BYTE_W +: BYTE_W] =
        (size == SZ_BYTE) ? store_data[BYTE_W-1:0] :
        (size == SZ_HALF) ? store_data[(gi%2)*BYTE_W +: BYTE_W] :
                            store_data[gi*BYTE_W +: BYTE_W];
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = ACCESS;
      ACCESS:  if (mem.mem_ready) state_next = DONE;
      // load/store still belong to the retiring instruction here.
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      be_reg        <= '0;
      we_reg        <= 1'b0;
      func3_reg     <= 3'b000;
      off_reg       <= 2'b00;
      load_data_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        addr_reg  <= {address[ADDR_WIDTH-1:2], 2'b00};
        wdata_reg <= wdata_next;
        be_reg    <= be_next;
        we_reg    <= store;
        func3_reg <= func_3;
        off_reg   <= off;
      end
      if (complete && !we_reg) begin
        load_data_reg <= align_result;
      end
    end
  end

  lsu_load_align u_align (
    .word   (mem.mem_rdata),
    .off    (off_reg),
    .func_3 (func3_reg),
    .result (align_result)
  );

  assign load_data           = load_data_reg;
  assign mem.mem_req         = (state_reg == ACCESS);
  assign mem.mem_we          = we_reg;
  assign mem.mem_addr        = addr_reg;
  assign mem.mem_wdata       = wdata_reg;
  assign mem.mem_byte_enable = be_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized
// transactions compared against a byte-arithmetic reference model.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic        store;
  logic [2:0]  func_3;
  logic [31:0] address;
  logic [31:0] store_data;
  logic [31:0] load_data;
  logic        stall;
  logic        misaligned;

  load_store_unit_if mem_if ();

  load_store_unit dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .store      (store),
    .func_3     (func_3),
    .address    (address),
    .store_data (store_data),
    .load_data  (load_data),
    .stall      (stall),
    .misaligned (misaligned),
    .mem        (mem_if)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_load_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int m_bytes(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic m_fault(input logic [2:0] f3, input logic [31:0] addr);
    return (addr % m_bytes(f3)) != 0;
  endfunction

  function automatic logic [31:0] m_be(input logic is_st, input logic [2:0] f3, input logic [31:0] addr);
    int n;
    if (!is_st) return 32'hF;
    n = m_bytes(f3);
    return ((32'd1 << n) - 32'd1) << (addr % 4);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (m_bytes(f3))
      1:       return (d & 32'hFF) * 32'h0101_0101;
      2:       return (d & 32'hFFFF) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rdata);
    int n;
    logic [31:0] mask;
    logic [31:0] v;
    n = m_bytes(f3);
    if (n == 4) return rdata;
    mask = (32'd1 << (8 * n)) - 32'd1;
    v = (rdata >> (8 * (addr % 4))) & mask;
    if (!f3[2] && ((v & ((mask >> 1) + 32'd1)) != 0)) v = v | ~mask;
    return v;
  endfunction

  // ---------------- transaction driver ----------------
  // Entered just after a rising edge with the DUT in IDLE.
  task automatic run_txn(input string name, input logic do_ld, input logic do_st,
                         input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] sdata, input logic [31:0] rdata, input int waits);
    logic        is_st;
    logic        flt;
    int          stall_cnt;
    logic [31:0] prev_ld;
    is_st     = do_st;
    flt       = m_fault(f3, addr);
    stall_cnt = 0;
    prev_ld   = exp_load_data;
    load = do_ld; store = do_st; func_3 = f3; address = addr; store_data = sdata;
    mem_if.mem_ready = 1'b0;
    mem_if.mem_rdata = $urandom;
    @(negedge clk);
    check({name, "_misaligned"}, misaligned, flt);
    if (flt) begin
      check({name, "_flt_stall"}, stall, 1'b0);
      check({name, "_flt_req"}, mem_if.mem_req, 1'b0);
      mem_if.mem_ready = 1'b1;  // must be ignored with no request out
      @(posedge clk); #1;
      @(negedge clk);
      check({name, "_flt_req2"}, mem_if.mem_req, 1'b0);
      check({name, "_flt_ld"}, load_data, exp_load_data);
      load = 1'b0; store = 1'b0; mem_if.mem_ready = 1'b0;
      @(posedge clk); #1;
      $display("txn %s ld=%0b st=%0b f3=%03b addr=%08h misaligned, not issued", name, do_ld, do_st, f3, addr);
      return;
    end
    if (stall) stall_cnt++;
    @(posedge clk); #1;
    for (int i = 0; i <= waits; i++) begin
      if (i == waits) begin
        mem_if.mem_ready = 1'b1;
        mem_if.mem_rdata = rdata;
      end
      @(negedge clk);
      if (stall) stall_cnt++;
      check({name, "_req"}, mem_if.mem_req, 1'b1);
      check({name, "_we"}, mem_if.mem_we, is_st);
      check({name, "_addr"}, mem_if.mem_addr, addr & ~32'd3);
      check({name, "_be"}, mem_if.mem_byte_enable, m_be(is_st, f3, addr));
      if (is_st) check({name, "_wdata"}, mem_if.mem_wdata, m_wdata(f3, sdata));
      @(posedge clk); #1;
    end
    mem_if.mem_ready = 1'b0;
    if (!is_st) exp_load_data = m_load(f3, addr, rdata);
    @(negedge clk);
    check({name, "_done_stall"}, stall, 1'b0);
    check({name, "_done_req"}, mem_if.mem_req, 1'b0);
    check({name, "_load_data"}, load_data, exp_load_data);
    check({name, "_stall_cycles"}, stall_cnt, waits + 2);
    load = 1'b0; store = 1'b0;
    @(posedge clk); #1;
    $display("txn %s ld=%0b st=%0b f3=%03b addr=%08h sdata=%08h rdata=%08h waits=%0d load_data=%08h (was %08h)",
             name, do_ld, do_st, f3, addr, sdata, rdata, waits, load_data, prev_ld);
  endtask

  // Load held off by memory, reset hits in the second ACCESS cycle.
  task automatic run_reset_mid_access();
    load = 1'b1; store = 1'b0; func_3 = LSU_W; address = 32'h0000_0500; store_data = '0;
    mem_if.mem_ready = 1'b0;
    @(posedge clk); #1;           // ACCESS 1
    @(negedge clk);
    check("rst_acc1_req", mem_if.mem_req, 1'b1);
    @(posedge clk); #1;           // ACCESS 2
    rst = 1'b1;
    load = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_load_data = 32'h0;
    @(negedge clk);
    check("rst_req", mem_if.mem_req, 1'b0);
    check("rst_state", 32'(dut.state_reg), 32'(IDLE));
    check("rst_stall", stall, 1'b0);
    check("rst_load_data", load_data, exp_load_data);
    @(posedge clk); #1;
    $display("txn rst_mid_access addr=00000500 abandoned, mem_req=%0b", mem_if.mem_req);
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; store = 1'b0; func_3 = 3'b000; address = '0; store_data = '0;
    mem_if.mem_ready = 1'b0; mem_if.mem_rdata = '0;
    exp_load_data = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset_req", mem_if.mem_req, 1'b0);
    check("reset_we", mem_if.mem_we, 1'b0);
    check("reset_addr", mem_if.mem_addr, 32'h0);
    check("reset_wdata", mem_if.mem_wdata, 32'h0);
    check("reset_be", mem_if.mem_byte_enable, 32'h0);
    check("reset_load_data", load_data, 32'h0);
    check("reset_stall", stall, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run_txn("sw",    1'b0, 1'b1, LSU_W,  32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 0);
    run_txn("sb",    1'b0, 1'b1, LSU_B,  32'h0000_0203, 32'h0000_00A5, 32'h0, 0);
    run_txn("lb",    1'b1, 1'b0, LSU_B,  32'h0000_0302, 32'h0, 32'h1280_FF34, 0);
    run_txn("lhu",   1'b1, 1'b0, LSU_HU, 32'h0000_0302, 32'h0, 32'h1280_FF34, 0);
    run_txn("sh",    1'b0, 1'b1, LSU_H,  32'h0000_0312, 32'h1234_5678, 32'h0, 1);
    run_txn("lw_mis",1'b1, 1'b0, LSU_W,  32'h0000_0401, 32'h0, 32'h0, 0);
    run_txn("lh_mis",1'b1, 1'b0, LSU_H,  32'h0000_0401, 32'h0, 32'h0, 0);
    run_txn("lb_ok", 1'b1, 1'b0, LSU_B,  32'h0000_0401, 32'h0, 32'h0000_9900, 0);
    run_txn("lw_wait",1'b1,1'b0, LSU_W,  32'h0000_0404, 32'h0, 32'hCAFE_F00D, 3);
    run_txn("ldst",  1'b1, 1'b1, LSU_H,  32'h0000_0602, 32'h0000_BEEF, 32'h1111_2222, 0);
    run_txn("lh",    1'b1, 1'b0, LSU_H,  32'h0000_0700, 32'h0, 32'h0000_8001, 2);
    run_reset_mid_access();

    for (int i = 0; i < 200; i++) begin
      logic        ld;
      logic        st;
      logic [31:0] a;
      ld = 1'($urandom_range(0, 1));
      st = 1'($urandom_range(0, 1));
      if (!ld && !st) ld = 1'b1;
      a = $urandom;
      run_txn("rnd", ld, st, 3'($urandom_range(0, 7)), a, $urandom, $urandom, $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
